// File: rtl/uart_prog_ctrl.sv
// Command sequencer between the UART byte interface and the CPU core. It parses
// L/G/S/. commands and hex words, writes instruction memory and arbitrates the TX path.
module uart_prog_ctrl #(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              rx_clr,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic [31:0]         acc_q, acc_d;
  logic [2:0]          nib_cnt_q, nib_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                halt_pend_q, halt_pend_d;
  logic                run_q, run_d;
  logic                rx_clr_q, rx_clr_d;
  logic                tx_wr_q, tx_wr_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                is_hex;
  logic [3:0]          nib;
  logic                halt_evt;
  logic                accept;

  always_comb begin
    is_hex = 1'b1;
    nib    = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      nib = rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // A halt sampled in RUN beats any byte arriving in the same cycle.
  assign halt_evt = (state_q == ST_RUN) && cpu_halted;
  assign accept   = rx_rdy && !tx_busy && !rx_clr_q && !halt_pend_q && !halt_evt;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    nib_cnt_d   = nib_cnt_q;
    addr_d      = addr_q;
    words_d     = words_q;
    halt_pend_d = halt_pend_q;
    run_d       = run_q;
    rx_clr_d    = 1'b0;
    tx_wr_d     = 1'b0;
    tx_data_d   = tx_data_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;

    // Address advances after the write strobe so addr/data hold during imem_we.
    if (we_q) begin
      addr_d  = addr_q + 1'b1;
      words_d = words_q + 1'b1;
      if (addr_q == LAST_ADDR) begin
        state_d = ST_IDLE;
      end
    end

    if (halt_evt) begin
      halt_pend_d = 1'b1;
      run_d       = 1'b0;
      state_d     = ST_IDLE;
    end

    if (halt_pend_q && !tx_busy && !tx_wr_q) begin
      tx_data_d   = 8'h21;
      tx_wr_d     = 1'b1;
      halt_pend_d = 1'b0;
    end else if (accept) begin
      rx_clr_d  = 1'b1;
      tx_wr_d   = 1'b1;
      tx_data_d = rx_data;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == 8'h4C) begin
            state_d   = ST_LOAD;
            addr_d    = '0;
            nib_cnt_d = 3'd0;
            words_d   = '0;
            acc_d     = 32'd0;
          end else if (rx_data == 8'h47) begin
            state_d = ST_RUN;
            run_d   = 1'b1;
          end
        end
        ST_LOAD: begin
          if (is_hex) begin
            acc_d = {acc_q[27:0], nib};
            if (nib_cnt_q == 3'd7) begin
              wdata_d   = {acc_q[27:0], nib};
              we_d      = 1'b1;
              nib_cnt_d = 3'd0;
            end else begin
              nib_cnt_d = nib_cnt_q + 3'd1;
            end
          end else if (rx_data == 8'h2E) begin
            state_d   = ST_IDLE;
            nib_cnt_d = 3'd0;
          end
        end
        ST_RUN: begin
          if (rx_data == 8'h53) begin
            state_d = ST_IDLE;
            run_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= 32'd0;
      nib_cnt_q   <= 3'd0;
      addr_q      <= '0;
      words_q     <= '0;
      halt_pend_q <= 1'b0;
      run_q       <= 1'b0;
      rx_clr_q    <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= 8'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      nib_cnt_q   <= nib_cnt_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      halt_pend_q <= halt_pend_d;
      run_q       <= run_d;
      rx_clr_q    <= rx_clr_d;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
    end
  end

  assign rx_clr       = rx_clr_q;
  assign tx_data      = tx_data_q;
  assign tx_wr        = tx_wr_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_run      = run_q;
  assign state        = state_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Scoreboard bench for uart_prog_ctrl: randomized command/hex streams against a
// byte-level reference model; a monitor pops expected echoes and writes.
module tb_uart_prog_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_rdy = 1'b0;
  logic          rx_clr;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          cpu_halted = 1'b0;
  logic [1:0]    state;
  logic [AW:0]   words_loaded;

  uart_prog_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_clr(rx_clr),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .cpu_halted(cpu_halted), .state(state), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from the strobe onward for a random number of cycles.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_wr) busy_cnt <= $urandom_range(0, 6);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = tx_wr | (busy_cnt != 0);

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]     exp_tx[$];
  logic [AW+31:0] exp_wr[$];

  // Reference model: 0=IDLE 1=LOAD 2=RUN.
  int          m_mode = 0;
  int          m_nib = 0;
  logic [31:0] m_acc = 32'd0;
  int          m_addr = 0;
  int          m_words = 0;
  logic        m_run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexchar(input int v);
    if (v < 10) return 8'h30 + 8'(v);
    if ($urandom_range(0, 1) == 1) return 8'h41 + 8'(v - 10);
    return 8'h61 + 8'(v - 10);
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int v;
    v = hexval(b);
    exp_tx.push_back(b);
    case (m_mode)
      0: begin
        if (b == 8'h4C) begin
          m_mode = 1; m_addr = 0; m_nib = 0; m_words = 0;
        end else if (b == 8'h47) begin
          m_mode = 2; m_run = 1'b1;
        end
      end
      1: begin
        if (v >= 0) begin
          m_acc = (m_acc << 4) | 32'(v);
          m_nib++;
          if (m_nib == 8) begin
            exp_wr.push_back({m_addr[AW-1:0], m_acc});
            m_nib = 0;
            m_words++;
            if (m_addr == DEPTH - 1) begin
              m_addr = 0; m_mode = 0;
            end else begin
              m_addr++;
            end
          end
        end else if (b == 8'h2E) begin
          m_mode = 0; m_nib = 0;
        end
      end
      default: begin
        if (b == 8'h53) begin
          m_mode = 0; m_run = 1'b0;
        end
      end
    endcase
  endtask

  logic [7:0]     pop_tx;
  logic [AW+31:0] pop_wr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_wr) begin
        if (exp_tx.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got 0x%0h, no byte expected", tx_data);
        end else begin
          pop_tx = exp_tx.pop_front();
          $display("tx byte 0x%02h (expected 0x%02h)", tx_data, pop_tx);
          chk("tx_byte", 64'(tx_data), 64'(pop_tx));
        end
      end
      if (imem_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL imem_unexpected: got addr %0d data 0x%08h, no write expected", imem_addr, imem_wdata);
        end else begin
          pop_wr = exp_wr.pop_front();
          $display("imem write addr %0d data 0x%08h", imem_addr, imem_wdata);
          chk("imem_write", 64'({imem_addr, imem_wdata}), 64'(pop_wr));
        end
      end
    end
  end

  task automatic wait_accept();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (rx_clr) seen = 1'b1;
    end
    chk("rx_accept", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    rx_data = b;
    rx_rdy  = 1'b1;
    wait_accept();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  task automatic send_word(input bit junk);
    logic [7:0] junk_set [9];
    junk_set = '{"x", "z", "-", " ", "L", "G", "S", "g", "?"};
    for (int i = 0; i < 8; i++) begin
      if (junk && $urandom_range(0, 5) == 0) send_byte(junk_set[$urandom_range(0, 8)]);
      send_byte(hexchar($urandom_range(0, 15)));
    end
  endtask

  task automatic check_regs(input string name);
    @(negedge clk);
    chk({name, "_state"}, 64'(state), 64'(m_mode));
    chk({name, "_words"}, 64'(words_loaded), 64'(m_words));
    chk({name, "_addr"}, 64'(imem_addr), 64'(m_addr));
    chk({name, "_run"}, 64'(cpu_run), 64'(m_run));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_rx_clr"}, 64'(rx_clr), 64'd0);
    chk({name, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({name, "_tx_wr"}, 64'(tx_wr), 64'd0);
    chk({name, "_imem_we"}, 64'(imem_we), 64'd0);
    chk({name, "_imem_addr"}, 64'(imem_addr), 64'd0);
    chk({name, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({name, "_cpu_run"}, 64'(cpu_run), 64'd0);
    chk({name, "_state"}, 64'(state), 64'd0);
    chk({name, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic model_reset();
    m_mode = 0; m_nib = 0; m_addr = 0; m_words = 0; m_run = 1'b0;
    exp_tx.delete();
    exp_wr.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rand_set [14];
    rand_set = '{"0", "3", "9", "a", "F", "c", "L", "G", "S", ".", "x", "7", "e", "B"};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load one word.
    send_str("L00A00093");
    check_regs("load_one");
    send_byte(8'h2E);

    // Lowercase digits and ignored junk.
    send_str("Ldexadbeef");
    check_regs("lower_junk");
    send_byte(8'h2E);

    // Abort a partial word.
    send_str("L12.");
    check_regs("abort");

    // Fill the whole memory, then a 17th word in IDLE.
    send_byte("L");
    for (int w = 0; w < DEPTH; w++) send_word(1'b1);
    check_regs("fill");
    send_word(1'b0);
    check_regs("fill_17th");

    // Run, then a halt racing an S byte.
    send_byte("G");
    check_regs("run");
    @(negedge clk);
    rx_data = 8'h53;
    rx_rdy = 1'b1;
    cpu_halted = 1'b1;
    exp_tx.push_back(8'h21);
    m_mode = 0;
    m_run = 1'b0;
    model_byte(8'h53);
    @(negedge clk);
    cpu_halted = 1'b0;
    chk("halt_cpu_run", 64'(cpu_run), 64'd0);
    chk("halt_state", 64'(state), 64'd0);
    wait_accept();
    check_regs("after_halt");

    // Random command/digit mix.
    for (int i = 0; i < 60; i++) send_byte(rand_set[$urandom_range(0, 13)]);
    check_regs("random");
    send_byte(8'h2E);
    send_byte(8'h53);
    check_regs("to_idle");

    // Reset in the middle of a word.
    send_str("L1234");
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte("L");
    send_word(1'b0);
    check_regs("post_reset");

    repeat (20) @(posedge clk);
    chk("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
